stream_mux_nto1: RTL and testbench

//  Parametrised N-input, WIDTH-bit registered stream multiplexer. Successor to the 2:1 combinational mux.

---
 rtl/stream_mux_nto1.sv | 86 ++++++++
 tb/tb_stream_mux_nto1.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1: N-input registered valid/ready stream mux with a one-entry output register.
// Define RR_ARB_EN for round-robin channel selection; otherwise the sel port picks the channel.
module stream_mux_nto1 #(
  parameter int WIDTH = 32,
  parameter int N_IN = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic [SEL_W-1:0] c;
  logic chosen, load, xfer;
  logic [WIDTH-1:0] ch [N_IN];
  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    assign ch[g] = in_data[g*WIDTH +: WIDTH];
  end
`ifdef RR_ARB_EN
  logic [SEL_W-1:0] rr_q, rr_d;
  // first valid channel after the last granted one, wrapping modulo N_IN
  always_comb begin
    chosen = 1'b0;
    c = '0;
    for (int k = 1; k <= N_IN; k++) begin
      if (!chosen && in_valid[(int'(rr_q) + k) % N_IN]) begin
        chosen = 1'b1;
        c = SEL_W'((int'(rr_q) + k) % N_IN);
      end
    end
  end
  assign rr_d = xfer ? c : rr_q;
  // pointer advances only on accepted transfers so the grant holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= SEL_W'(N_IN - 1);
    else rr_q <= rr_d;
  end
`else
  // fixed select; out-of-range sel chooses nothing
  always_comb begin
    c = sel;
    chosen = 32'(sel) < N_IN;
  end
`endif
  assign load = !out_valid || out_ready;
  assign in_ready = (rst_n && load && chosen) ? (N_IN'(1) << c) : '0;
  assign xfer = |(in_ready & in_valid);
  // next state: load on transfer, drain on consumer accept, otherwise hold
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    src_d = src_q;
    if (xfer) begin
      state_d = FULL;
      data_d = ch[c];
      src_d = c;
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end
  // output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q <= '0;
      src_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      src_q <= src_d;
    end
  end
  assign out_valid = state_q == FULL;
  assign out_data = data_q;
  assign out_src = src_q;
endmodule

// File: tb/tb_stream_mux_nto1.sv
// tb_stream_mux_nto1: directed checks of the registered stream mux (4-input and 3-input instances)
module tb_stream_mux_nto1;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [127:0] in_data = '0;
  logic [3:0] in_valid = '0;
  logic [3:0] in_ready;
  logic [1:0] sel = '0;
  logic [31:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [1:0] out_src;
  logic [95:0] in_data3 = '0;
  logic [2:0] in_valid3 = '0;
  logic [2:0] in_ready3;
  logic [1:0] sel3 = '0;
  logic [31:0] out_data3;
  logic out_valid3;
  logic out_ready3 = 1'b0;
  logic [1:0] out_src3;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  stream_mux_nto1 #(.WIDTH(32), .N_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src)
  );

  stream_mux_nto1 #(.WIDTH(32), .N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_src(out_src3)
  );

  task automatic test_reset();
    sel = 2'd2;
    in_valid = 4'b0100;
    out_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL reset_data got %h want 0", out_data); else passed++;
    total++; if (out_src !== 2'd0) $display("FAIL reset_src got %0d want 0", out_src); else passed++;
    total++; if (in_ready !== 4'b0) $display("FAIL reset_in_ready got %b want 0000", in_ready); else passed++;
    total++; if (out_valid3 !== 1'b0) $display("FAIL reset_valid3 got %b want 0", out_valid3); else passed++;
    in_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    @(negedge clk);
    sel = 2'd2;
    in_data[64 +: 32] = 32'hA5A5A5A5;
    in_valid = 4'b0100;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0100) $display("FAIL fixed_in_ready got %b want 0100", in_ready); else passed++;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) $display("FAIL fixed_valid got %b want 1", out_valid); else passed++;
    total++; if (out_data !== 32'hA5A5A5A5) $display("FAIL fixed_data got %h want a5a5a5a5", out_data); else passed++;
    total++; if (out_src !== 2'd2) $display("FAIL fixed_src got %0d want 2", out_src); else passed++;
    in_valid = '0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 32'hA5A5A5A5) $display("FAIL drain_data_hold got %h want a5a5a5a5", out_data); else passed++;
  endtask

  task automatic test_backpressure();
    sel = 2'd0;
    in_data[0 +: 32] = 32'h11111111;
    in_valid = 4'b0001;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      sel = 2'(i + 1);
      for (int j = 0; j < 4; j++) in_data[j*32 +: 32] = 32'hC0DE0000 + 32'(i * 4 + j);
      #1;
      total++; if (in_ready !== 4'b0) $display("FAIL bp_in_ready[%0d] got %b want 0000", i, in_ready); else passed++;
      @(negedge clk);
      total++; if (out_data !== 32'h11111111) $display("FAIL bp_data[%0d] got %h want 11111111", i, out_data); else passed++;
      total++; if (out_valid !== 1'b1 || out_src !== 2'd0) $display("FAIL bp_valid_src[%0d] got %b/%0d want 1/0", i, out_valid, out_src); else passed++;
    end
    in_valid = '0;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL bp_release got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    sel = 2'd1;
    in_valid = 4'b0010;
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data[32 +: 32] = 32'(i);
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_data !== 32'(i) || out_src !== 2'd1)
        $display("FAIL b2b[%0d] got v=%b d=%h s=%0d want v=1 d=%h s=1", i, out_valid, out_data, out_src, 32'(i));
      else passed++;
    end
    in_valid = '0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_end got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_sel_oob();
    sel3 = 2'd3;
    in_valid3 = 3'b111;
    in_data3 = {32'h33333333, 32'h22222222, 32'h11111111};
    out_ready3 = 1'b1;
    #1;
    total++; if (in_ready3 !== 3'b000) $display("FAIL oob_in_ready got %b want 000", in_ready3); else passed++;
    @(negedge clk);
    total++; if (out_valid3 !== 1'b0) $display("FAIL oob_valid got %b want 0", out_valid3); else passed++;
    sel3 = 2'd2;
    #1;
    total++; if (in_ready3 !== 3'b100) $display("FAIL n3_in_ready got %b want 100", in_ready3); else passed++;
    @(negedge clk);
    total++; if (out_valid3 !== 1'b1 || out_src3 !== 2'd2 || out_data3 !== 32'h33333333)
      $display("FAIL n3_out got v=%b s=%0d d=%h want v=1 s=2 d=33333333", out_valid3, out_src3, out_data3);
    else passed++;
    in_valid3 = '0;
  endtask

  task automatic test_rr();
    logic [1:0] exp_src [8];
    exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1};
    for (int j = 0; j < 4; j++) in_data[j*32 +: 32] = 32'hAB000000 + 32'(j);
    sel = 2'd2;
    out_ready = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_src !== exp_src[i] || out_data !== 32'hAB000000 + 32'(exp_src[i]))
        $display("FAIL rr[%0d] got v=%b s=%0d d=%h want v=1 s=%0d", i, out_valid, out_src, out_data, exp_src[i]);
      else passed++;
      if (i == 4) in_valid = 4'b1010;
    end
    in_valid = '0;
  endtask

  initial begin
    test_reset();
`ifdef RR_ARB_EN
    test_rr();
`else
    test_fixed();
    test_backpressure();
    test_back_to_back();
    test_sel_oob();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
